// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst-master state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0]  AXI_SIZE_4B  = 3'd2;
  localparam int unsigned AXI_4K_BYTES = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StFin
  } state_e;

  // True when a burst of len+1 four-byte beats starting at addr runs past the 4 KiB page.
  function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len);
    logic [13:0] end_byte;
    end_byte = {2'b00, addr[11:2], 2'b00} + {4'b0000, len, 2'b00} + 14'd4;
    return end_byte > 14'(AXI_4K_BYTES);
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-command AXI4 master: one INCR write or read burst per accepted command.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int unsigned G_DATAWIDTH  = 32,
  parameter int unsigned G_ID_WIDTH   = 1,
  parameter int unsigned G_ADDRWIDTH  = 32,
  parameter int unsigned G_WSTRBWIDTH = 4
) (
  input  logic                    s_aclk,
  input  logic                    s_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [G_ADDRWIDTH-1:0]  cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [G_ID_WIDTH-1:0]   cmd_id,
  input  logic [G_DATAWIDTH-1:0]  wr_tdata,
  input  logic                    wr_tvalid,
  output logic                    wr_tready,
  output logic [G_DATAWIDTH-1:0]  rd_tdata,
  output logic                    rd_tvalid,
  input  logic                    rd_tready,
  output logic                    rd_tlast,
  output logic                    done,
  output logic                    err,
  output logic [G_ID_WIDTH-1:0]   m_axi_awid,
  output logic [G_ADDRWIDTH-1:0]  m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [G_DATAWIDTH-1:0]  m_axi_wdata,
  output logic [G_WSTRBWIDTH-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [G_ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [G_ID_WIDTH-1:0]   m_axi_arid,
  output logic [G_ADDRWIDTH-1:0]  m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [G_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [G_DATAWIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_e                   state_q;
  logic [G_ADDRWIDTH-3:0]   addr_q;
  logic [7:0]               len_q;
  logic [7:0]               cnt_q;
  logic [G_ID_WIDTH-1:0]    id_q;
  logic                     err_q;
  logic                     done_q;
  logic                     ready_q;
  logic                     awvalid_q;
  logic                     arvalid_q;
  logic                     bready_q;

  logic last_beat;
  logic w_hs;
  logic r_hs;

  assign last_beat = (cnt_q == len_q);
  assign w_hs      = (state_q == StW) && wr_tvalid && m_axi_wready;
  assign r_hs      = (state_q == StR) && m_axi_rvalid && rd_tready;

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q) begin
            ready_q <= 1'b0;
            addr_q  <= cmd_addr[G_ADDRWIDTH-1:2];
            len_q   <= cmd_len;
            id_q    <= cmd_id;
            cnt_q   <= '0;
            // A page-crossing burst is refused outright with no bus traffic.
            if (crosses_4k(cmd_addr[11:0], cmd_len)) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              err_q <= 1'b0;
              if (cmd_write) begin
                awvalid_q <= 1'b1;
                state_q   <= StAw;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= StAr;
              end
            end
          end
        end
        StAw: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            state_q   <= StW;
          end
        end
        StW: begin
          if (w_hs) begin
            if (last_beat) begin
              cnt_q    <= '0;
              bready_q <= 1'b1;
              state_q  <= StB;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StB: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            err_q    <= err_q | (m_axi_bresp != RESP_OKAY) | (m_axi_bid != id_q);
            done_q   <= 1'b1;
            state_q  <= StFin;
          end
        end
        StAr: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= StR;
          end
        end
        StR: begin
          if (r_hs) begin
            // rlast is only cross-checked; the local count decides where the burst ends.
            err_q <= err_q | (m_axi_rresp != RESP_OKAY) | (m_axi_rlast != last_beat);
            if (last_beat) begin
              cnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StFin: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;

  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = {addr_q, 2'b00};
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata  = wr_tdata;
  assign m_axi_wstrb  = '1;
  assign m_axi_wvalid = (state_q == StW) && wr_tvalid;
  assign m_axi_wlast  = (state_q == StW) && last_beat;
  assign wr_tready    = (state_q == StW) && m_axi_wready;

  assign m_axi_bready = bready_q;

  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = {addr_q, 2'b00};
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = arvalid_q;

  assign rd_tdata     = m_axi_rdata;
  assign rd_tvalid    = (state_q == StR) && m_axi_rvalid;
  assign rd_tlast     = (state_q == StR) && last_beat;
  assign m_axi_rready = (state_q == StR) && rd_tready;

  logic unused_bits;
  assign unused_bits = ^{cmd_addr[1:0], m_axi_rid};

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: word-memory slave, transaction-level model, per-cycle compare.
module tb_axi_burst_master;

  logic        s_aclk = 1'b0;
  logic        s_areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [0:0]  cmd_id;
  logic [31:0] wr_tdata;
  logic        wr_tvalid, wr_tready;
  logic [31:0] rd_tdata;
  logic        rd_tvalid, rd_tready, rd_tlast;
  logic        done, err;
  logic [0:0]  m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_burst_master dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tlast(rd_tlast),
    .done(done), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 s_aclk = ~s_aclk;

  // Zero-wait memory slave over a 4 KiB window.
  logic [31:0] smem [1024];
  logic [9:0]  s_waddr, s_raddr;
  logic [7:0]  s_rcnt, s_rlen;
  logic [0:0]  s_wid;
  logic [1:0]  bresp_inject;

  assign m_axi_awready = 1'b1;
  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_rresp   = 2'b00;
  assign m_axi_rdata   = smem[s_raddr];
  assign m_axi_rlast   = (s_rcnt == s_rlen);

  always @(posedge s_aclk) begin
    if (s_areset) begin
      m_axi_bvalid <= 1'b0;
      m_axi_rvalid <= 1'b0;
    end else begin
      if (m_axi_awvalid) begin
        s_waddr <= m_axi_awaddr[11:2];
        s_wid   <= m_axi_awid;
      end
      if (m_axi_wvalid) begin
        smem[s_waddr] <= m_axi_wdata;
        s_waddr       <= s_waddr + 10'd1;
        if (m_axi_wlast) begin
          m_axi_bvalid <= 1'b1;
          m_axi_bid    <= s_wid;
          m_axi_bresp  <= bresp_inject;
        end
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid) begin
        s_raddr      <= m_axi_araddr[11:2];
        s_rlen       <= m_axi_arlen;
        s_rcnt       <= 8'd0;
        m_axi_rid    <= m_axi_arid;
        m_axi_rvalid <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        if (s_rcnt == s_rlen) begin
          m_axi_rvalid <= 1'b0;
        end else begin
          s_rcnt  <= s_rcnt + 8'd1;
          s_raddr <= s_raddr + 10'd1;
        end
      end
    end
  end

  // Model state: the command in flight and the words the memory must now hold.
  bit          exp_wr, exp_cross, exp_err;
  logic [31:0] exp_addr;
  logic [7:0]  exp_len;
  logic [0:0]  exp_id;
  logic [31:0] wr_q [256];
  logic [31:0] ref_mem [1024];
  logic [31:0] got_q [$];

  int nvec = 0;
  int nfail = 0;

  // Directed checks are handed to the compare process so it alone keeps the counts.
  string       pin_name;
  logic [31:0] pin_act, pin_exp;
  int          pin_seq = 0;
  int          pin_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    pin_name = name;
    pin_act  = act;
    pin_exp  = exp;
    pin_seq++;
    wait (pin_seen == pin_seq);
  endtask

  logic [31:0] last_awaddr;
  logic [7:0]  last_awlen;
  bit          aw_seen, ar_seen, prev_done;
  int          w_idx, r_idx;

  initial begin
    forever begin
      @(negedge s_aclk);
      if (pin_seq != pin_seen) begin
        chk(pin_name, pin_act, pin_exp);
        pin_seen = pin_seq;
      end
      if (s_areset) begin
        aw_seen = 0; ar_seen = 0; w_idx = 0; r_idx = 0; prev_done = 0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          aw_seen = 0; ar_seen = 0; w_idx = 0; r_idx = 0;
        end
        if (m_axi_wvalid) begin
          chk("w_after_aw", 32'(aw_seen), 32'd1);
          chk("wdata", m_axi_wdata, wr_q[w_idx[7:0]]);
          chk("wlast", 32'(m_axi_wlast), 32'(w_idx == int'(exp_len)));
          chk("wstrb", 32'(m_axi_wstrb), 32'hF);
          if (m_axi_wready) w_idx++;
        end
        if (ar_seen && r_idx <= int'(exp_len))
          chk("rready_mirror", 32'(m_axi_rready), 32'(rd_tready));
        if (rd_tvalid) begin
          chk("rd_tdata", rd_tdata, ref_mem[(int'(exp_addr[11:2]) + r_idx) % 1024]);
          chk("rd_tlast", 32'(rd_tlast), 32'(r_idx == int'(exp_len)));
          if (rd_tready) r_idx++;
        end
        if (m_axi_awvalid) begin
          chk("aw_allowed", 32'(exp_wr && !exp_cross), 32'd1);
          chk("awaddr", m_axi_awaddr, {exp_addr[31:2], 2'b00});
          chk("awlen", 32'(m_axi_awlen), 32'(exp_len));
          chk("awsize_burst", 32'({m_axi_awsize, m_axi_awburst}), 32'({3'd2, 2'b01}));
          chk("awid", 32'(m_axi_awid), 32'(exp_id));
          last_awaddr = m_axi_awaddr;
          last_awlen  = m_axi_awlen;
          if (m_axi_awready) aw_seen = 1;
        end
        if (m_axi_arvalid) begin
          chk("ar_allowed", 32'(!exp_wr && !exp_cross), 32'd1);
          chk("araddr", m_axi_araddr, {exp_addr[31:2], 2'b00});
          chk("arlen", 32'(m_axi_arlen), 32'(exp_len));
          chk("arsize_burst", 32'({m_axi_arsize, m_axi_arburst}), 32'({3'd2, 2'b01}));
          chk("arid", 32'(m_axi_arid), 32'(exp_id));
          if (m_axi_arready) ar_seen = 1;
        end
        if (done) begin
          chk("done_err", 32'(err), 32'(exp_err));
          chk("done_beats", 32'(exp_wr ? w_idx : r_idx), exp_cross ? 32'd0 : 32'(exp_len) + 1);
          chk("done_single", 32'(prev_done), 32'd0);
        end
        prev_done = done;
      end
    end
  end

  // Issues one command and runs it to done; abort_at >= 0 returns after that many W beats.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [0:0] id_v, input bit toggle, input int abort_at,
                         output int lat);
    int   wi;
    int   budget;
    bit   hs;
    bit   got_done;
    logic e_acc;
    exp_wr    = wr;
    exp_addr  = addr;
    exp_len   = len;
    exp_id    = id_v;
    exp_cross = (int'(addr[11:2]) * 4 + (int'(len) + 1) * 4) > 4096;
    exp_err   = exp_cross || (wr && bresp_inject != 2'b00);
    got_q.delete();
    lat = 0;
    @(posedge s_aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id_v;
    budget = 0;
    forever begin
      @(negedge s_aclk);
      if (cmd_ready) break;
      budget++;
      if (budget > 50) begin
        cmd_valid = 1'b0;
        pin("accept_timeout", 32'd1, 32'd0);
        return;
      end
    end
    @(posedge s_aclk); #1;
    cmd_valid = 1'b0;
    e_acc = err;
    rd_tready = !wr;
    wi = 0;
    got_done = 0;
    for (int k = 0; k < 2000 && !got_done; k++) begin
      if (wr) begin
        wr_tvalid = (wi <= int'(len));
        wr_tdata  = (wi <= int'(len)) ? wr_q[wi[7:0]] : 32'd0;
      end
      @(negedge s_aclk);
      hs = wr_tvalid && wr_tready;
      if (rd_tvalid && rd_tready) got_q.push_back(rd_tdata);
      if (done) begin
        got_done = 1;
        lat = k + 1;
      end
      @(posedge s_aclk); #1;
      if (hs) wi++;
      if (toggle) rd_tready = !rd_tready;
      if (abort_at >= 0 && wi == abort_at) return;
    end
    wr_tvalid = 1'b0;
    rd_tready = 1'b0;
    pin("err_at_accept", 32'(e_acc), 32'(exp_cross));
    if (!got_done) pin("done_timeout", 32'd1, 32'd0);
    if (wr && !exp_err)
      for (int i = 0; i <= int'(len); i++) ref_mem[(int'(addr[11:2]) + i) % 1024] = wr_q[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    logic        c0, c1;
    int          lat;
    s_areset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wr_tdata = 0; wr_tvalid = 0; rd_tready = 0; bresp_inject = 2'b00;
    repeat (3) @(posedge s_aclk);
    #1;
    rv = 32'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
              m_axi_rready, rd_tvalid, done, err});
    s_areset = 1'b0;
    @(negedge s_aclk); c0 = cmd_ready;
    @(posedge s_aclk); #1; c1 = cmd_ready;
    pin("reset_outputs", rv, 32'd0);
    pin("ready_at_release", 32'(c0), 32'd0);
    pin("ready_after_release", 32'(c1), 32'd1);

    // Write 0xA0..0xA3 at 0x100, then read it back.
    for (int i = 0; i < 4; i++) wr_q[i] = 32'hA0 + i;
    run_cmd(1'b1, 32'h100, 8'd3, 1'b0, 1'b0, -1, lat);
    pin("t1_awaddr", last_awaddr, 32'h100);
    pin("t1_awlen", 32'(last_awlen), 32'd3);
    pin("t1_err", 32'(err), 32'd0);
    run_cmd(1'b0, 32'h100, 8'd3, 1'b0, 1'b0, -1, lat);
    pin("t2_beats", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) pin("t2_data", got_q[i], 32'hA0 + i);

    // Misaligned start is forced to a word; read back with rd_tready toggling.
    for (int i = 0; i < 8; i++) wr_q[i] = 32'hB0 + i;
    run_cmd(1'b1, 32'h302, 8'd7, 1'b1, 1'b0, -1, lat);
    pin("t3_awaddr", last_awaddr, 32'h300);
    run_cmd(1'b0, 32'h300, 8'd7, 1'b1, 1'b1, -1, lat);
    pin("t3_beats", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) pin("t3_data", got_q[i], 32'hB0 + i);

    // 256 beats ending exactly on the 4 KiB boundary.
    for (int i = 0; i < 256; i++) wr_q[i] = 32'hC000_0000 + i;
    run_cmd(1'b1, 32'hC00, 8'd255, 1'b0, 1'b0, -1, lat);
    pin("t4_err", 32'(err), 32'd0);
    run_cmd(1'b0, 32'hC00, 8'd255, 1'b0, 1'b0, -1, lat);
    pin("t4_beats", 32'(got_q.size()), 32'd256);
    pin("t4_last", got_q[255], 32'hC000_00FF);

    // Page-crossing write is refused.
    for (int i = 0; i < 4; i++) wr_q[i] = 32'hE0 + i;
    run_cmd(1'b1, 32'hFF8, 8'd3, 1'b0, 1'b0, -1, lat);
    pin("t5_done_within_2", 32'(lat >= 1 && lat <= 2), 32'd1);
    pin("t5_err", 32'(err), 32'd1);

    // SLVERR on a 1-beat write; the next accept must clear err.
    bresp_inject = 2'b10;
    wr_q[0] = 32'hDEAD_0001;
    run_cmd(1'b1, 32'h040, 8'd0, 1'b0, 1'b0, -1, lat);
    pin("t6_latency", 32'(lat), 32'd4);
    pin("t6_err", 32'(err), 32'd1);
    bresp_inject = 2'b00;
    run_cmd(1'b0, 32'h100, 8'd0, 1'b0, 1'b0, -1, lat);
    pin("t6_read_data", got_q[0], 32'hA0);
    pin("t6_err_cleared", 32'(err), 32'd0);

    // Reset after 2 of 4 write beats.
    for (int i = 0; i < 4; i++) wr_q[i] = 32'hD0 + i;
    run_cmd(1'b1, 32'h200, 8'd3, 1'b0, 1'b0, 2, lat);
    s_areset = 1'b1;
    @(posedge s_aclk); #1;
    rv = 32'({m_axi_wvalid, m_axi_awvalid});
    s_areset = 1'b0;
    wr_tvalid = 1'b0;
    @(negedge s_aclk); c0 = cmd_ready;
    @(posedge s_aclk); #1; c1 = cmd_ready;
    pin("t7_valids_dropped", rv, 32'd0);
    pin("t7_ready_at_release", 32'(c0), 32'd0);
    pin("t7_ready_after_release", 32'(c1), 32'd1);

    run_cmd(1'b0, 32'h300, 8'd0, 1'b1, 1'b0, -1, lat);
    pin("t8_recover_data", got_q[0], 32'hB0);

    repeat (2) @(posedge s_aclk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
